hazard_scoreboard: RTL and testbench

Parametrised stall controller for the 5-stage MIPS pipeline, replacing the purely combinational stall unit. It holds an internal scoreboard of in-flight destination registers and their remaining Tnew, shifted every cycle, instead of taking decoded E/M state as inputs. It also holds a mult/div busy countdown and the eret-after-mtc0 interlock. It sits beside the D stage and drives PC/D-register enables and the E-register clear.

---
 rtl/hazard_scoreboard.sv | 147 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Purpose : D-stage stall controller; tracks in-flight GPR writers, the mult/div busy window and eret-after-mtc0.
// Latency : zero; every output is combinational from the scoreboard state and the current D-stage inputs.
// Backpr. : stall holds PC and D (pc_en=d_en=0) and bubbles E (e_clr=1); flush kills every tracked entry.
//
// Ports:
//   clk, reset (async, active-low)
//   d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew : decoded D-stage operand/result info
//   d_md, d_md_start, d_md_div, d_mtc0, d_eret               : D-stage instruction class flags
//   flush                                                    : exception flush of everything after D
//   pc_en, d_en, e_clr                                       : pipeline register controls
//   md_busy, stall_cause {eret, md, data}, stall_cycles      : status
//
// Optional macro STALL_STAT_EN: when defined, stall_cycles is a free-running 32-bit count of
// stalled cycles; when undefined it is tied to zero.
module hazard_scoreboard #(
   parameter int NSTAGE     = 3,
   parameter int TW         = 3,
   parameter int MULT_LAT   = 5,
   parameter int DIV_LAT    = 10,
   parameter int EPC_WSTAGE = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          d_valid,
   input  logic [4:0]    d_rs,
   input  logic [4:0]    d_rt,
   input  logic [TW-1:0] d_tuse_rs,
   input  logic [TW-1:0] d_tuse_rt,
   input  logic [4:0]    d_a3,
   input  logic [TW-1:0] d_tnew,
   input  logic          d_md,
   input  logic          d_md_start,
   input  logic          d_md_div,
   input  logic          d_mtc0,
   input  logic          d_eret,
   input  logic          flush,
   output logic          pc_en,
   output logic          d_en,
   output logic          e_clr,
   output logic          md_busy,
   output logic [2:0]    stall_cause,
   output logic [31:0]   stall_cycles
);

   typedef struct packed {
      logic          vld;
      logic [4:0]    a3;
      logic [TW-1:0] tnew;
      logic          mtc0;
   } ent_t;

   localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
   localparam int CW     = $clog2(MD_MAX + 1);
   localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);
   localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);

   ent_t          ent    [NSTAGE];
   ent_t          ent_sh [NSTAGE];
   logic [CW-1:0] md_cnt;

   logic data_hz;
   logic mtc0_ahead;
   logic md_hz;
   logic eret_hz;
   logic stall;
   logic issue;

   // Hazard detection against every tracked entry.
   always_comb begin
      data_hz    = 1'b0;
      mtc0_ahead = 1'b0;
      for (int i = 0; i < NSTAGE; i++) begin
         if (ent[i].vld && (ent[i].a3 != 5'd0)) begin
            if ((ent[i].a3 == d_rs) && (d_tuse_rs < ent[i].tnew)) data_hz = 1'b1;
            if ((ent[i].a3 == d_rt) && (d_tuse_rt < ent[i].tnew)) data_hz = 1'b1;
         end
         // Only entries that have not yet written EPC can race an eret.
         if ((i < EPC_WSTAGE) && ent[i].vld && ent[i].mtc0) mtc0_ahead = 1'b1;
      end
   end

   assign md_busy = (md_cnt != '0);
   assign md_hz   = d_md && md_busy;
   assign eret_hz = d_eret && mtc0_ahead;

   assign stall_cause = d_valid ? {eret_hz, md_hz, data_hz} : 3'b000;
   assign stall       = |stall_cause;
   assign pc_en       = !stall;
   assign d_en        = !stall;
   assign e_clr       = stall;
   assign issue       = d_valid && !stall && !flush;

   // Next scoreboard contents: entry 0 takes the issuing D instruction (or a bubble),
   // older entries age by one stage with tnew saturating at zero.
   always_comb begin
      for (int i = 0; i < NSTAGE; i++) ent_sh[i] = '0;
      if (issue) begin
         ent_sh[0].vld  = 1'b1;
         ent_sh[0].a3   = d_a3;
         ent_sh[0].tnew = d_tnew;
         ent_sh[0].mtc0 = d_mtc0;
      end
      for (int i = 1; i < NSTAGE; i++) begin
         ent_sh[i] = ent[i-1];
         if (ent[i-1].tnew != '0) ent_sh[i].tnew = ent[i-1].tnew - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NSTAGE; i++) ent[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < NSTAGE; i++) ent[i] <= '0;
      end else begin
         for (int i = 0; i < NSTAGE; i++) ent[i] <= ent_sh[i];
      end
   end

   // HI/LO completes regardless of a flush, so the busy countdown ignores it
   // except that a flushed mult/div never starts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         md_cnt <= '0;
      end else if (issue && d_md_start) begin
         md_cnt <= d_md_div ? DIV_CNT : MULT_CNT;
      end else if (md_busy) begin
         md_cnt <= md_cnt - 1'b1;
      end
   end

`ifdef STALL_STAT_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= 32'd0;
      end else if (stall) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose : self-checking bench for hazard_scoreboard (default parameters).
// Latency : outputs are compared on the falling edge of the cycle whose inputs produced them.
// Backpr. : n/a; stimulus is a fixed per-scenario sequence with queued expectations.
module tb_hazard_scoreboard;

   logic        clk;
   logic        reset;
   logic        d_valid;
   logic [4:0]  d_rs;
   logic [4:0]  d_rt;
   logic [2:0]  d_tuse_rs;
   logic [2:0]  d_tuse_rt;
   logic [4:0]  d_a3;
   logic [2:0]  d_tnew;
   logic        d_md;
   logic        d_md_start;
   logic        d_md_div;
   logic        d_mtc0;
   logic        d_eret;
   logic        flush;
   logic        pc_en;
   logic        d_en;
   logic        e_clr;
   logic        md_busy;
   logic [2:0]  stall_cause;
   logic [31:0] stall_cycles;

   logic [6:0]  obs;
   logic [6:0]  exp_q [$];
   int          vecs;
   int          fails;

`ifdef STALL_STAT_EN
   localparam logic [31:0] EXP_STAT7 = 32'd7;
`else
   localparam logic [31:0] EXP_STAT7 = 32'd0;
`endif

   hazard_scoreboard dut (
      .clk          (clk),
      .reset        (reset),
      .d_valid      (d_valid),
      .d_rs         (d_rs),
      .d_rt         (d_rt),
      .d_tuse_rs    (d_tuse_rs),
      .d_tuse_rt    (d_tuse_rt),
      .d_a3         (d_a3),
      .d_tnew       (d_tnew),
      .d_md         (d_md),
      .d_md_start   (d_md_start),
      .d_md_div     (d_md_div),
      .d_mtc0       (d_mtc0),
      .d_eret       (d_eret),
      .flush        (flush),
      .pc_en        (pc_en),
      .d_en         (d_en),
      .e_clr        (e_clr),
      .md_busy      (md_busy),
      .stall_cause  (stall_cause),
      .stall_cycles (stall_cycles)
   );

   assign obs = {pc_en, d_en, e_clr, md_busy, stall_cause};

   always #5 clk = ~clk;

   // Expected {pc_en, d_en, e_clr, md_busy, stall_cause} for a given cause set.
   function automatic logic [6:0] exp_out(input logic [2:0] cause, input logic busy);
      logic st;
      st = |cause;
      return {!st, !st, st, busy, cause};
   endfunction

   task automatic idle();
      d_valid = 0; d_rs = 0; d_rt = 0; d_tuse_rs = 0; d_tuse_rt = 0;
      d_a3 = 0; d_tnew = 0; d_md = 0; d_md_start = 0; d_md_div = 0;
      d_mtc0 = 0; d_eret = 0; flush = 0;
   endtask

   task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [2:0] tus, input logic [2:0] tut,
                        input logic [4:0] a3, input logic [2:0] tnew);
      idle();
      d_valid = 1; d_rs = rs; d_rt = rt; d_tuse_rs = tus; d_tuse_rt = tut;
      d_a3 = a3; d_tnew = tnew;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int n);
      idle();
      repeat (n) tick();
   endtask

   task automatic test_reset();
      logic [6:0] e;
      for (int k = 0; k < 2; k++) begin
         if (k == 1) begin
            d_valid = 1; d_md = 1; d_eret = 1; d_rs = 5'd1;
         end
         exp_q.push_back(exp_out(3'b000, 1'b0));
         @(negedge clk);
         e = exp_q.pop_front();
         vecs++;
         if (obs !== e) begin
            fails++;
            $display("FAIL reset step %0d: got %b want %b", k, obs, e);
         end
         vecs++;
         if (stall_cycles !== 32'd0) begin
            fails++;
            $display("FAIL reset_stat step %0d: got %0d want 0", k, stall_cycles);
         end
      end
      @(posedge clk);
      #1;
      reset = 1;
      idle();
   endtask

   task automatic test_data();
      logic [6:0] e;
      settle(4);
      for (int k = 0; k < 10; k++) begin
         case (k)
            0:       begin set_d(5, 0, 1, 3, 1, 2);  exp_q.push_back(exp_out(3'b000, 1'b0)); end
            1:       begin set_d(1, 3, 1, 1, 4, 1);  exp_q.push_back(exp_out(3'b001, 1'b0)); end
            2:       begin set_d(1, 3, 1, 1, 4, 1);  exp_q.push_back(exp_out(3'b000, 1'b0)); end
            3:       begin set_d(5, 0, 1, 3, 6, 2);  exp_q.push_back(exp_out(3'b000, 1'b0)); end
            4, 5:    begin set_d(0, 6, 0, 0, 9, 1);  exp_q.push_back(exp_out(3'b001, 1'b0)); end
            6:       begin set_d(0, 6, 0, 0, 9, 1);  exp_q.push_back(exp_out(3'b000, 1'b0)); end
            7:       begin set_d(0, 0, 0, 0, 7, 2);  exp_q.push_back(exp_out(3'b000, 1'b0)); end
            8:       begin set_d(7, 0, 2, 3, 10, 1); exp_q.push_back(exp_out(3'b000, 1'b0)); end
            default: begin set_d(7, 0, 0, 0, 0, 0); d_valid = 0;
                           exp_q.push_back(exp_out(3'b000, 1'b0)); end
         endcase
         @(negedge clk);
         e = exp_q.pop_front();
         vecs++;
         if (obs !== e) begin
            fails++;
            $display("FAIL data step %0d: got %b want %b", k, obs, e);
         end
         tick();
      end
   endtask

   task automatic test_zero_reg();
      logic [6:0] e;
      settle(4);
      for (int k = 0; k < 5; k++) begin
         set_d(0, 0, 0, 0, 0, 2);
         exp_q.push_back(exp_out(3'b000, 1'b0));
         @(negedge clk);
         e = exp_q.pop_front();
         vecs++;
         if (obs !== e) begin
            fails++;
            $display("FAIL zero_reg step %0d: got %b want %b", k, obs, e);
         end
         tick();
      end
   endtask

   task automatic test_md();
      logic [6:0] e;
      settle(12);
      for (int k = 0; k < 19; k++) begin
         if (k == 0) begin
            set_d(0, 0, 7, 7, 0, 0); d_md = 1; d_md_start = 1; d_md_div = 1;
            exp_q.push_back(exp_out(3'b000, 1'b0));
         end else if (k <= 10) begin
            set_d(0, 0, 7, 7, 2, 1); d_md = 1;
            exp_q.push_back(exp_out(3'b010, 1'b1));
         end else if (k == 11) begin
            set_d(0, 0, 7, 7, 2, 1); d_md = 1;
            exp_q.push_back(exp_out(3'b000, 1'b0));
         end else if (k == 12) begin
            set_d(0, 0, 7, 7, 0, 0); d_md = 1; d_md_start = 1;
            exp_q.push_back(exp_out(3'b000, 1'b0));
         end else if (k == 13) begin
            set_d(9, 10, 1, 1, 11, 1);
            exp_q.push_back(exp_out(3'b000, 1'b1));
         end else if (k <= 17) begin
            set_d(0, 0, 7, 7, 12, 1); d_md = 1;
            exp_q.push_back(exp_out(3'b010, 1'b1));
         end else begin
            set_d(0, 0, 7, 7, 12, 1); d_md = 1;
            exp_q.push_back(exp_out(3'b000, 1'b0));
         end
         @(negedge clk);
         e = exp_q.pop_front();
         vecs++;
         if (obs !== e) begin
            fails++;
            $display("FAIL md step %0d: got %b want %b", k, obs, e);
         end
         tick();
      end
   endtask

   task automatic test_eret();
      logic [6:0] e;
      settle(12);
      for (int k = 0; k < 5; k++) begin
         if (k == 0) begin
            set_d(0, 5, 7, 1, 0, 0); d_mtc0 = 1;
            exp_q.push_back(exp_out(3'b000, 1'b0));
         end else begin
            set_d(0, 0, 7, 7, 0, 0); d_eret = 1;
            exp_q.push_back(exp_out((k <= 2) ? 3'b100 : 3'b000, 1'b0));
         end
         @(negedge clk);
         e = exp_q.pop_front();
         vecs++;
         if (obs !== e) begin
            fails++;
            $display("FAIL eret step %0d: got %b want %b", k, obs, e);
         end
         tick();
      end
   endtask

   task automatic test_multi_cause();
      logic [6:0] e;
      settle(12);
      for (int k = 0; k < 7; k++) begin
         case (k)
            0:       begin set_d(0, 0, 7, 7, 0, 0); d_md = 1; d_md_start = 1;
                           exp_q.push_back(exp_out(3'b000, 1'b0)); end
            1:       begin set_d(0, 0, 7, 7, 3, 2);
                           exp_q.push_back(exp_out(3'b000, 1'b1)); end
            2, 3:    begin set_d(3, 0, 0, 7, 13, 1); d_md = 1;
                           exp_q.push_back(exp_out(3'b011, 1'b1)); end
            4, 5:    begin set_d(3, 0, 0, 7, 13, 1); d_md = 1;
                           exp_q.push_back(exp_out(3'b010, 1'b1)); end
            default: begin set_d(3, 0, 0, 7, 13, 1); d_md = 1;
                           exp_q.push_back(exp_out(3'b000, 1'b0)); end
         endcase
         @(negedge clk);
         e = exp_q.pop_front();
         vecs++;
         if (obs !== e) begin
            fails++;
            $display("FAIL multi_cause step %0d: got %b want %b", k, obs, e);
         end
         tick();
      end
   endtask

   task automatic test_flush();
      logic [6:0] e;
      settle(12);
      for (int k = 0; k < 7; k++) begin
         case (k)
            0:       begin set_d(0, 0, 7, 7, 0, 0); d_md = 1; d_md_start = 1;
                           exp_q.push_back(exp_out(3'b000, 1'b0)); end
            1:       begin set_d(0, 0, 7, 7, 2, 2);
                           exp_q.push_back(exp_out(3'b000, 1'b1)); end
            2:       begin set_d(0, 0, 7, 7, 8, 2); flush = 1;
                           exp_q.push_back(exp_out(3'b000, 1'b1)); end
            3:       begin set_d(2, 8, 0, 0, 14, 1);
                           exp_q.push_back(exp_out(3'b000, 1'b1)); end
            4, 5:    begin set_d(0, 0, 7, 7, 15, 1); d_md = 1;
                           exp_q.push_back(exp_out(3'b010, 1'b1)); end
            default: begin set_d(0, 0, 7, 7, 15, 1); d_md = 1;
                           exp_q.push_back(exp_out(3'b000, 1'b0)); end
         endcase
         @(negedge clk);
         e = exp_q.pop_front();
         vecs++;
         if (obs !== e) begin
            fails++;
            $display("FAIL flush step %0d: got %b want %b", k, obs, e);
         end
         tick();
      end
   endtask

   task automatic test_stats_reset();
      logic [6:0] e;
      settle(2);
      reset = 0;
      #2;
      reset = 1;
      for (int k = 0; k < 8; k++) begin
         if (k == 0) begin
            set_d(0, 0, 7, 7, 0, 0); d_md = 1; d_md_start = 1; d_md_div = 1;
            exp_q.push_back(exp_out(3'b000, 1'b0));
         end else begin
            set_d(0, 0, 7, 7, 2, 1); d_md = 1;
            exp_q.push_back(exp_out(3'b010, 1'b1));
         end
         @(negedge clk);
         e = exp_q.pop_front();
         vecs++;
         if (obs !== e) begin
            fails++;
            $display("FAIL stats step %0d: got %b want %b", k, obs, e);
         end
         tick();
      end
      #1;
      vecs++;
      if (stall_cycles !== EXP_STAT7) begin
         fails++;
         $display("FAIL stats_count: got %0d want %0d", stall_cycles, EXP_STAT7);
      end
      reset = 0;
      #1;
      exp_q.push_back(exp_out(3'b000, 1'b0));
      e = exp_q.pop_front();
      vecs++;
      if (obs !== e) begin
         fails++;
         $display("FAIL midreset_out: got %b want %b", obs, e);
      end
      vecs++;
      if (stall_cycles !== 32'd0) begin
         fails++;
         $display("FAIL midreset_stat: got %0d want 0", stall_cycles);
      end
      @(posedge clk);
      #1;
      reset = 1;
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clk   = 0;
      reset = 0;
      vecs  = 0;
      fails = 0;
      idle();
      test_reset();
      test_data();
      test_zero_reg();
      test_md();
      test_eret();
      test_multi_cause();
      test_flush();
      test_stats_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
